// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised little-endian data RAM behind a
// load/store request port. Byte, half and word accesses are supported with
// sign/zero extension. Accesses that straddle a word boundary take two RAM
// cycles under a small IDLE/SPLIT/RESP state machine.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LAST_BYTE = 32'(4 * DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        RESP
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t        state_q, state_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   low_word_q, low_word_d;
    logic [2:0]    func_q, func_d;
    logic [1:0]    off_q, off_d;
    logic          we_q, we_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   hi_wdata_q, hi_wdata_d;
    logic [3:0]    hi_be_q, hi_be_d;

    logic          accept;
    logic [2:0]    size_bytes;
    logic [3:0]    size_mask;
    logic          func_legal;
    logic [32:0]   end_addr;
    logic          req_err;
    logic          req_split;
    logic [AW-1:0] req_idx;
    logic [63:0]   wide_wdata;
    logic [7:0]    wide_be;
    logic [31:0]   rd_lo;
    logic [31:0]   rd_hi;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    // Pick the access size out of funct3 and sign/zero extend a loaded value.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [2:0]  func);
        logic [31:0] res;
        case (func[1:0])
            2'b00:   res = func[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = func[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign req_ready = rst_n && (state_q != SPLIT);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Decode the incoming request: size, legality, range, split and lane
    // placement. The range check spans the whole access so that a straddling
    // store past the end is rejected before its first word is touched.
    always_comb begin
        case (req_func[1:0])
            2'b00:   begin size_bytes = 3'd1; size_mask = 4'b0001; end
            2'b01:   begin size_bytes = 3'd2; size_mask = 4'b0011; end
            default: begin size_bytes = 3'd4; size_mask = 4'b1111; end
        endcase
        if (req_we) begin
            func_legal = (req_func == 3'b000) || (req_func == 3'b001) ||
                         (req_func == 3'b010);
        end else begin
            func_legal = (req_func == 3'b000) || (req_func == 3'b001) ||
                         (req_func == 3'b010) || (req_func == 3'b100) ||
                         (req_func == 3'b101);
        end
        end_addr   = {1'b0, req_addr} + 33'(size_bytes) - 33'd1;
        req_err    = !func_legal || end_addr[32] || (end_addr[31:0] > LAST_BYTE);
        req_split  = ({2'b00, req_addr[1:0]} + {1'b0, size_bytes}) > 4'd4;
        req_idx    = req_addr[AW+1:2];
        wide_wdata = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
        wide_be    = {4'b0, size_mask} << req_addr[1:0];
        rd_lo      = mem[req_idx];
        rd_hi      = mem[idx_q + AW'(1)];
    end

    // Next-state, response and RAM write-port logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        low_word_d  = low_word_q;
        func_d      = func_q;
        off_d       = off_q;
        we_d        = we_q;
        idx_d       = idx_q;
        hi_wdata_d  = hi_wdata_q;
        hi_be_d     = hi_be_q;
        wr_en       = 1'b0;
        wr_idx      = req_idx;
        wr_data     = wide_wdata[31:0];
        wr_be       = wide_be[3:0];

        case (state_q)
            SPLIT: begin
                wr_en       = we_q;
                wr_idx      = idx_q + AW'(1);
                wr_data     = hi_wdata_q;
                wr_be       = hi_be_q;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = we_q ? 32'b0 :
                              extend_load(32'({rd_hi, low_word_q} >> {off_q, 3'b000}), func_q);
                state_d     = RESP;
            end
            default: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'b0;
                        state_d     = RESP;
                    end else if (req_split) begin
                        wr_en      = req_we;
                        low_word_d = rd_lo;
                        func_d     = req_func;
                        off_d      = req_addr[1:0];
                        we_d       = req_we;
                        idx_d      = req_idx;
                        hi_wdata_d = wide_wdata[63:32];
                        hi_be_d    = wide_be[7:4];
                        state_d    = SPLIT;
                    end else begin
                        wr_en       = req_we;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = req_we ? 32'b0 :
                                      extend_load(rd_lo >> {req_addr[1:0], 3'b000}, req_func);
                        state_d     = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            low_word_q  <= 32'b0;
            func_q      <= 3'b0;
            off_q       <= 2'b0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            hi_wdata_q  <= 32'b0;
            hi_be_q     <= 4'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            low_word_q  <= low_word_d;
            func_q      <= func_d;
            off_q       <= off_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            hi_wdata_q  <= hi_wdata_d;
            hi_be_q     <= hi_be_d;
        end
    end

    // RAM byte-lane write port; contents survive reset, but reset blocks the
    // pending second-word write of an interrupted split store.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed requests push their expected
// response into a scoreboard queue; a monitor pops and compares every
// response, including the cycle at which it must arrive.
module tb_data_mem_responder;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    exp_t sb_q[$];
    int   cycle_cnt = 0;
    int   n_checks  = 0;
    int   n_fails   = 0;

    data_mem_responder #(.DEPTH_WORDS(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_func  (req_func),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Free-running clock and a cycle counter used to check response latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one request at a falling edge, wait (bounded) for acceptance and
    // optionally record the expected response in the scoreboard.
    task automatic applyStimulus(input string name, input logic we,
                                 input logic [2:0] func, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int lat, input bit push_exp);
        exp_t e;
        int   waited;
        req_valid = 1'b1;
        req_we    = we;
        req_func  = func;
        req_addr  = addr;
        req_wdata = wdata;
        waited    = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL %s_accept: req_ready stayed 0, required 1", name);
        end else if (push_exp) begin
            e.name  = name;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.due   = cycle_cnt + lat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Monitor: every response must match the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, required no response");
                end else begin
                    e = sb_q.pop_front();
                    checkOutput({e.name, "_rdata"}, rsp_rdata, e.rdata);
                    checkOutput({e.name, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
                    checkOutput({e.name, "_cycle"}, cycle_cnt, e.due);
                end
            end
        end
    end

    initial begin
        int drain;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_func  = 3'b0;
        req_addr  = 32'b0;
        req_wdata = 32'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("reset_ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready", {31'b0, req_ready}, 32'd1);

        // Word store then sign/zero-extended reads of the same location.
        applyStimulus("sw_10", 1, 3'b010, 32'h10, 32'h8000_00FF, 32'h0, 0, 1, 1);
        applyStimulus("lb_10", 0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFFF, 0, 1, 1);
        applyStimulus("lbu_10", 0, 3'b100, 32'h10, 32'h0, 32'h0000_00FF, 0, 1, 1);
        applyStimulus("lh_10", 0, 3'b001, 32'h10, 32'h0, 32'h0000_00FF, 0, 1, 1);
        applyStimulus("lhu_10", 0, 3'b101, 32'h10, 32'h0, 32'h0000_00FF, 0, 1, 1);
        applyStimulus("lw_10", 0, 3'b010, 32'h10, 32'h0, 32'h8000_00FF, 0, 1, 1);

        // Byte store into lane 3 preserves the other lanes.
        applyStimulus("sb_13", 1, 3'b000, 32'h13, 32'h1234_56AA, 32'h0, 0, 1, 1);
        applyStimulus("lw_10b", 0, 3'b010, 32'h10, 32'h0, 32'hAA00_00FF, 0, 1, 1);
        applyStimulus("lb_13", 0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFAA, 0, 1, 1);

        // Store then load in its response cycle returns the new byte.
        applyStimulus("sb_30", 1, 3'b000, 32'h30, 32'h0000_005A, 32'h0, 0, 1, 1);
        applyStimulus("lbu_30", 0, 3'b100, 32'h30, 32'h0, 32'h0000_005A, 0, 1, 1);

        // Misaligned word store straddling 0x20/0x24.
        applyStimulus("sw_20", 1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 1, 1);
        applyStimulus("sw_24", 1, 3'b010, 32'h24, 32'h5555_5555, 32'h0, 0, 1, 1);
        applyStimulus("sw_21", 1, 3'b010, 32'h21, 32'h1122_3344, 32'h0, 0, 2, 1);
        checkOutput("split_ready_low", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        checkOutput("resp_ready_high", {31'b0, req_ready}, 32'd1);
        applyStimulus("lw_20", 0, 3'b010, 32'h20, 32'h0, 32'h2233_44EF, 0, 1, 1);
        applyStimulus("lw_24", 0, 3'b010, 32'h24, 32'h0, 32'h5555_5511, 0, 1, 1);
        applyStimulus("lw_21", 0, 3'b010, 32'h21, 32'h0, 32'h1122_3344, 0, 2, 1);
        applyStimulus("lh_23", 0, 3'b001, 32'h23, 32'h0, 32'h0000_1122, 0, 2, 1);

        // Range boundary at the top of the 4 KiB RAM.
        applyStimulus("sw_ffc", 1, 3'b010, 32'hFFC, 32'hCAFE_F00D, 32'h0, 0, 1, 1);
        applyStimulus("lw_ffc", 0, 3'b010, 32'hFFC, 32'h0, 32'hCAFE_F00D, 0, 1, 1);
        applyStimulus("lh_fff", 0, 3'b001, 32'hFFF, 32'h0, 32'h0, 1, 1, 1);
        applyStimulus("sw_ffe", 1, 3'b010, 32'hFFE, 32'h9999_9999, 32'h0, 1, 1, 1);
        applyStimulus("lw_ffc2", 0, 3'b010, 32'hFFC, 32'h0, 32'hCAFE_F00D, 0, 1, 1);
        applyStimulus("lw_wrap", 0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h0, 1, 1, 1);
        applyStimulus("lb_1000", 0, 3'b000, 32'h1000, 32'h0, 32'h0, 1, 1, 1);

        // Illegal function codes have no RAM effect.
        applyStimulus("ld_f011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 1);
        applyStimulus("st_f100", 1, 3'b100, 32'h10, 32'h0BAD_0BAD, 32'h0, 1, 1, 1);
        applyStimulus("lw_10c", 0, 3'b010, 32'h10, 32'h0, 32'hAA00_00FF, 0, 1, 1);

        // Back-to-back aligned loads, one per cycle.
        applyStimulus("b2b_0", 0, 3'b010, 32'h10, 32'h0, 32'hAA00_00FF, 0, 1, 1);
        applyStimulus("b2b_1", 0, 3'b010, 32'h20, 32'h0, 32'h2233_44EF, 0, 1, 1);
        applyStimulus("b2b_2", 0, 3'b010, 32'h24, 32'h0, 32'h5555_5511, 0, 1, 1);
        applyStimulus("b2b_3", 0, 3'b010, 32'hFFC, 32'h0, 32'hCAFE_F00D, 0, 1, 1);

        // Reset during the second cycle of a split store.
        applyStimulus("sw_40", 1, 3'b010, 32'h40, 32'h0, 32'h0, 0, 1, 1);
        applyStimulus("sw_44", 1, 3'b010, 32'h44, 32'h0, 32'h0, 0, 1, 1);
        applyStimulus("sw_41", 1, 3'b010, 32'h41, 32'h9988_7766, 32'h0, 0, 2, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_split_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_split_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_split_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("rst_split_ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus("lw_40", 0, 3'b010, 32'h40, 32'h0, 32'h8877_6600, 0, 1, 1);
        applyStimulus("lw_44", 0, 3'b010, 32'h44, 32'h0, 32'h0000_0000, 0, 1, 1);

        drain = 0;
        while (sb_q.size() != 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
